// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack side, branch redirect
// side and the decoded-instruction valid/ready side.
interface instr_fetch_unit_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 24
);
  logic               MemReq;
  logic [PC_W-1:0]    MemAddr;
  logic               MemAck;
  logic [INSTR_W-1:0] MemData;
  logic               Redirect;
  logic [PC_W-1:0]    RedirectPC;
  logic               InstrValid;
  logic               InstrReady;
  logic [INSTR_W-1:0] Instr;
  logic [PC_W-1:0]    InstrPC;
  logic [3:0]         Opcode;

  // Fetch unit side
  modport master (
    output MemReq, MemAddr, InstrValid, Instr, InstrPC, Opcode,
    input  MemAck, MemData, Redirect, RedirectPC, InstrReady
  );

  // Memory / branch unit / decode side
  modport slave (
    input  MemReq, MemAddr, InstrValid, Instr, InstrPC, Opcode,
    output MemAck, MemData, Redirect, RedirectPC, InstrReady
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetch PC, one-outstanding memory request,
// shift-register instruction FIFO (entry 0 is the head) and branch flush.
// Optional feature macro: HALT_DETECT_EN (stop fetching after opcode 4'hF).
module instr_fetch_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 24,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic               Clock,
  input logic               Reset,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned          CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned          OP_W  = 4;
  localparam logic [CNT_W-1:0]     FULL  = CNT_W'(DEPTH);

`ifdef HALT_DETECT_EN
  typedef enum logic [1:0] {FETCH = 2'd0, DISCARD = 2'd1, HALTED = 2'd2} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, DISCARD = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    pending_pc_q, pending_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               mem_req_q, mem_req_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic               accept;
  logic               push;
  logic               pop;
  logic               flush;
  logic [CNT_W-1:0]   wr_idx;

  // Next-state, FIFO control and next request/valid flags
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    push         = 1'b0;
    flush        = 1'b0;
    accept       = mem_req_q & bus.MemAck;
    pop          = valid_q & bus.InstrReady;
    count_d      = count_q;
    wr_idx       = '0;
    mem_req_d    = 1'b0;
    valid_d      = 1'b0;

    case (state_q)
      FETCH: begin
        if (bus.Redirect) begin
          flush = 1'b1;
          if (!mem_req_q || bus.MemAck) begin
            fetch_pc_d = bus.RedirectPC;
          end else begin
            // Request already on the bus must complete; its data is dropped
            pending_pc_d = bus.RedirectPC;
            state_d      = DISCARD;
          end
        end else if (accept) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_W'(1);
`ifdef HALT_DETECT_EN
          if (bus.MemData[INSTR_W-1 -: OP_W] == {OP_W{1'b1}}) begin
            state_d = HALTED;
          end
`endif
        end
      end
      DISCARD: begin
        if (bus.Redirect) begin
          flush = 1'b1;
        end
        if (bus.MemAck) begin
          fetch_pc_d = bus.Redirect ? bus.RedirectPC : pending_pc_q;
          state_d    = FETCH;
        end else if (bus.Redirect) begin
          pending_pc_d = bus.RedirectPC;
        end
      end
`ifdef HALT_DETECT_EN
      HALTED: begin
        if (bus.Redirect) begin
          flush      = 1'b1;
          fetch_pc_d = bus.RedirectPC;
          state_d    = FETCH;
        end
      end
`endif
      default: ;
    endcase

    if (flush) begin
      pop     = 1'b0;
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    wr_idx    = count_q - CNT_W'(pop);
    mem_req_d = (state_d == DISCARD) || ((state_d == FETCH) && (count_d < FULL));
    valid_d   = (count_d != '0);
  end

  // Control state registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      count_q      <= '0;
      mem_req_q    <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      mem_req_q    <= mem_req_d;
      valid_q      <= valid_d;
    end
  end

  // FIFO storage: shift toward entry 0 on pop, write behind the last live entry
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (!flush) begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          pc_mem[i]    <= pc_mem[i+1];
          instr_mem[i] <= instr_mem[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == wr_idx) begin
            pc_mem[i]    <= fetch_pc_q;
            instr_mem[i] <= bus.MemData;
          end
        end
      end
    end
  end

  assign bus.MemReq     = mem_req_q;
  assign bus.MemAddr    = fetch_pc_q;
  assign bus.InstrValid = valid_q;
  assign bus.Instr      = instr_mem[0];
  assign bus.InstrPC    = pc_mem[0];
  assign bus.Opcode     = instr_mem[0][INSTR_W-1 -: OP_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run checked against a queue-based transaction model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [15:0] pc;
    logic [23:0] d;
  } ent_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  instr_fetch_unit_if #(.PC_W(16), .INSTR_W(24)) bus ();
  instr_fetch_unit_if #(.PC_W(16), .INSTR_W(24)) bus2 ();

  instr_fetch_unit #(.PC_W(16), .INSTR_W(24), .DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  instr_fetch_unit #(.PC_W(16), .INSTR_W(24), .DEPTH(DEPTH), .RESET_PC(16'hFFFF)) u_wrap (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic ack, input logic [23:0] data, input logic red,
                       input logic [15:0] rpc, input logic rdy);
    bus.MemAck     = ack;
    bus.MemData    = data;
    bus.Redirect   = red;
    bus.RedirectPC = rpc;
    bus.InstrReady = rdy;
  endtask

  task automatic drive2(input logic ack, input logic [23:0] data, input logic rdy);
    bus2.MemAck     = ack;
    bus2.MemData    = data;
    bus2.Redirect   = 1'b0;
    bus2.RedirectPC = 16'h0000;
    bus2.InstrReady = rdy;
  endtask

  // Reset, release at a falling edge, then one rising edge so the first request is up
  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [23:0] mem_word(input logic [15:0] a);
    logic [23:0] w;
    w = {a[7:0], a} ^ 24'h5A3C96;
`ifdef HALT_DETECT_EN
    if (w[23:20] == 4'hF) w[23:20] = 4'hE;
`endif
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 24'hFFFFFF, 1'b0, 16'h0, 1'b1);
    repeat (2) tick();
    n_cmp++;
    if ({bus.MemReq, bus.MemAddr} !== {1'b0, 16'h0000}) begin
      n_err++; $display("FAIL reset_req_addr: got %h want %h", {bus.MemReq, bus.MemAddr}, {1'b0, 16'h0000});
    end
    n_cmp++;
    if ({bus.InstrValid, bus.Instr, bus.InstrPC, bus.Opcode} !== 45'h0) begin
      n_err++; $display("FAIL reset_head: got %h want 0", {bus.InstrValid, bus.Instr, bus.InstrPC, bus.Opcode});
    end
    drive(1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus.MemReq, bus.MemAddr, bus.InstrValid} !== {1'b1, 16'h0000, 1'b0}) begin
      n_err++; $display("FAIL reset_first_req: got %h want %h", {bus.MemReq, bus.MemAddr, bus.InstrValid}, {1'b1, 16'h0000, 1'b0});
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int n = 0; n < 8; n++) begin
      n_cmp++;
      if ({bus.MemReq, bus.MemAddr} !== {1'b1, 16'(n)}) begin
        n_err++; $display("FAIL stream_req c%0d: got %h want %h", n, {bus.MemReq, bus.MemAddr}, {1'b1, 16'(n)});
      end
      if (n > 0) begin
        n_cmp++;
        if ({bus.InstrValid, bus.InstrPC, bus.Instr, bus.Opcode} !==
            {1'b1, 16'(n - 1), 24'h100000 + 24'(n - 1), 4'h1}) begin
          n_err++; $display("FAIL stream_head c%0d: got %h want %h", n,
                            {bus.InstrValid, bus.InstrPC, bus.Instr, bus.Opcode},
                            {1'b1, 16'(n - 1), 24'h100000 + 24'(n - 1), 4'h1});
        end
      end
      drive(1'b1, 24'h100000 + 24'(n), 1'b0, 16'h0, 1'b1);
      tick();
    end
    drive(1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic       exp_req   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] exp_addr [7] = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd3};
    logic [15:0] exp_pc   [7] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2};
    do_reset();
    for (int n = 0; n < 7; n++) begin
      n_cmp++;
      if ({bus.MemReq, bus.MemAddr} !== {exp_req[n], exp_addr[n]}) begin
        n_err++; $display("FAIL bp_req c%0d: got %h want %h", n, {bus.MemReq, bus.MemAddr}, {exp_req[n], exp_addr[n]});
      end
      n_cmp++;
      if (n == 0) begin
        if (bus.InstrValid !== 1'b0) begin
          n_err++; $display("FAIL bp_valid c0: got %b want 0", bus.InstrValid);
        end
      end else if ({bus.InstrValid, bus.InstrPC, bus.Instr} !== {1'b1, exp_pc[n], 24'h100000 + 24'(exp_pc[n])}) begin
        n_err++; $display("FAIL bp_head c%0d: got %h want %h", n, {bus.InstrValid, bus.InstrPC, bus.Instr},
                          {1'b1, exp_pc[n], 24'h100000 + 24'(exp_pc[n])});
      end
      drive(1'b1, 24'h100000 + 24'(exp_addr[n]), 1'b0, 16'h0, n >= 4);
      tick();
    end
    drive(1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_redirect_delayed_ack();
    do_reset();
    drive(1'b0, 24'h0, 1'b1, 16'h0040, 1'b1);
    tick();
    for (int n = 1; n < 4; n++) begin
      n_cmp++;
      if ({bus.MemReq, bus.MemAddr, bus.InstrValid} !== {1'b1, 16'h0000, 1'b0}) begin
        n_err++; $display("FAIL rda_hold c%0d: got %h want %h", n, {bus.MemReq, bus.MemAddr, bus.InstrValid}, {1'b1, 16'h0000, 1'b0});
      end
      drive(n == 3, 24'hABCDEF, 1'b0, 16'h0, 1'b1);
      tick();
    end
    n_cmp++;
    if ({bus.MemReq, bus.MemAddr, bus.InstrValid} !== {1'b1, 16'h0040, 1'b0}) begin
      n_err++; $display("FAIL rda_newreq: got %h want %h", {bus.MemReq, bus.MemAddr, bus.InstrValid}, {1'b1, 16'h0040, 1'b0});
    end
    drive(1'b1, 24'h100040, 1'b0, 16'h0, 1'b1);
    tick();
    n_cmp++;
    if ({bus.InstrValid, bus.InstrPC, bus.Instr} !== {1'b1, 16'h0040, 24'h100040}) begin
      n_err++; $display("FAIL rda_head: got %h want %h", {bus.InstrValid, bus.InstrPC, bus.Instr}, {1'b1, 16'h0040, 24'h100040});
    end
    drive(1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    drive(1'b1, 24'h100000, 1'b0, 16'h0, 1'b0);
    tick();
    n_cmp++;
    if ({bus.MemReq, bus.MemAddr, bus.InstrValid, bus.InstrPC} !== {1'b1, 16'h0001, 1'b1, 16'h0000}) begin
      n_err++; $display("FAIL rap_pre: got %h want %h", {bus.MemReq, bus.MemAddr, bus.InstrValid, bus.InstrPC},
                        {1'b1, 16'h0001, 1'b1, 16'h0000});
    end
    drive(1'b1, 24'h100001, 1'b1, 16'h0100, 1'b1);
    tick();
    n_cmp++;
    if ({bus.MemReq, bus.MemAddr, bus.InstrValid} !== {1'b1, 16'h0100, 1'b0}) begin
      n_err++; $display("FAIL rap_flush: got %h want %h", {bus.MemReq, bus.MemAddr, bus.InstrValid}, {1'b1, 16'h0100, 1'b0});
    end
    drive(1'b1, 24'h100100, 1'b0, 16'h0, 1'b0);
    tick();
    n_cmp++;
    if ({bus.InstrValid, bus.InstrPC, bus.Instr, bus.MemAddr} !== {1'b1, 16'h0100, 24'h100100, 16'h0101}) begin
      n_err++; $display("FAIL rap_head: got %h want %h", {bus.InstrValid, bus.InstrPC, bus.Instr, bus.MemAddr},
                        {1'b1, 16'h0100, 24'h100100, 16'h0101});
    end
    drive(1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_wrap();
    drive2(1'b1, 24'h200000, 1'b1);
    do_reset();
    n_cmp++;
    if ({bus2.MemReq, bus2.MemAddr} !== {1'b1, 16'hFFFF}) begin
      n_err++; $display("FAIL wrap_first: got %h want %h", {bus2.MemReq, bus2.MemAddr}, {1'b1, 16'hFFFF});
    end
    tick();
    n_cmp++;
    if ({bus2.MemReq, bus2.MemAddr, bus2.InstrValid, bus2.InstrPC, bus2.Opcode} !==
        {1'b1, 16'h0000, 1'b1, 16'hFFFF, 4'h2}) begin
      n_err++; $display("FAIL wrap_second: got %h want %h", {bus2.MemReq, bus2.MemAddr, bus2.InstrValid, bus2.InstrPC, bus2.Opcode},
                        {1'b1, 16'h0000, 1'b1, 16'hFFFF, 4'h2});
    end
    tick();
    n_cmp++;
    if ({bus2.MemAddr, bus2.InstrPC} !== {16'h0001, 16'h0000}) begin
      n_err++; $display("FAIL wrap_third: got %h want %h", {bus2.MemAddr, bus2.InstrPC}, {16'h0001, 16'h0000});
    end
    drive2(1'b0, 24'h0, 1'b0);
  endtask

  task automatic test_opcode_f();
    do_reset();
    for (int n = 0; n < 4; n++) begin
      n_cmp++;
      if ({bus.MemReq, bus.MemAddr} !== {1'b1, 16'(n)}) begin
        n_err++; $display("FAIL opf_req c%0d: got %h want %h", n, {bus.MemReq, bus.MemAddr}, {1'b1, 16'(n)});
      end
      drive(1'b1, (n == 3) ? 24'hF00000 : 24'h100000 + 24'(n), 1'b0, 16'h0, 1'b1);
      tick();
    end
    n_cmp++;
    if ({bus.InstrValid, bus.InstrPC, bus.Instr, bus.Opcode} !== {1'b1, 16'h0003, 24'hF00000, 4'hF}) begin
      n_err++; $display("FAIL opf_head: got %h want %h", {bus.InstrValid, bus.InstrPC, bus.Instr, bus.Opcode},
                        {1'b1, 16'h0003, 24'hF00000, 4'hF});
    end
`ifdef HALT_DETECT_EN
    n_cmp++;
    if (bus.MemReq !== 1'b0) begin
      n_err++; $display("FAIL halt_req_drop: got %b want 0", bus.MemReq);
    end
    drive(1'b1, 24'h0, 1'b0, 16'h0, 1'b1);
    tick();
    n_cmp++;
    if ({bus.MemReq, bus.InstrValid} !== 2'b00) begin
      n_err++; $display("FAIL halt_stay: got %b want 00", {bus.MemReq, bus.InstrValid});
    end
    drive(1'b1, 24'h0, 1'b1, 16'h0008, 1'b1);
    tick();
    n_cmp++;
    if ({bus.MemReq, bus.MemAddr, bus.InstrValid} !== {1'b1, 16'h0008, 1'b0}) begin
      n_err++; $display("FAIL halt_resume: got %h want %h", {bus.MemReq, bus.MemAddr, bus.InstrValid}, {1'b1, 16'h0008, 1'b0});
    end
    drive(1'b1, 24'h100008, 1'b0, 16'h0, 1'b1);
    tick();
    n_cmp++;
    if ({bus.InstrValid, bus.InstrPC, bus.Instr, bus.MemAddr} !== {1'b1, 16'h0008, 24'h100008, 16'h0009}) begin
      n_err++; $display("FAIL halt_refetch: got %h want %h", {bus.InstrValid, bus.InstrPC, bus.Instr, bus.MemAddr},
                        {1'b1, 16'h0008, 24'h100008, 16'h0009});
    end
`else
    n_cmp++;
    if ({bus.MemReq, bus.MemAddr} !== {1'b1, 16'h0004}) begin
      n_err++; $display("FAIL opf_continue: got %h want %h", {bus.MemReq, bus.MemAddr}, {1'b1, 16'h0004});
    end
    drive(1'b1, 24'h100004, 1'b0, 16'h0, 1'b1);
    tick();
    n_cmp++;
    if ({bus.InstrValid, bus.InstrPC, bus.Instr, bus.MemAddr} !== {1'b1, 16'h0004, 24'h100004, 16'h0005}) begin
      n_err++; $display("FAIL opf_next: got %h want %h", {bus.InstrValid, bus.InstrPC, bus.Instr, bus.MemAddr},
                        {1'b1, 16'h0004, 24'h100004, 16'h0005});
    end
`endif
    drive(1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, 24'h0, 1'b1, 16'h0020, 1'b1);
    tick();
    n_cmp++;
    if ({bus.MemReq, bus.MemAddr} !== {1'b1, 16'h0000}) begin
      n_err++; $display("FAIL rmid_discard: got %h want %h", {bus.MemReq, bus.MemAddr}, {1'b1, 16'h0000});
    end
    drive(1'b0, 24'h0, 1'b0, 16'h0, 1'b1);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.MemReq, bus.MemAddr, bus.InstrValid} !== {1'b0, 16'h0000, 1'b0}) begin
      n_err++; $display("FAIL rmid_async: got %h want %h", {bus.MemReq, bus.MemAddr, bus.InstrValid}, {1'b0, 16'h0000, 1'b0});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus.MemReq, bus.MemAddr, bus.InstrValid} !== {1'b1, 16'h0000, 1'b0}) begin
      n_err++; $display("FAIL rmid_restart: got %h want %h", {bus.MemReq, bus.MemAddr, bus.InstrValid}, {1'b1, 16'h0000, 1'b0});
    end
    drive(1'b1, 24'h100000, 1'b0, 16'h0, 1'b1);
    tick();
    n_cmp++;
    if ({bus.InstrValid, bus.InstrPC, bus.MemAddr} !== {1'b1, 16'h0000, 16'h0001}) begin
      n_err++; $display("FAIL rmid_first: got %h want %h", {bus.InstrValid, bus.InstrPC, bus.MemAddr}, {1'b1, 16'h0000, 16'h0001});
    end
    drive(1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
  endtask

  // Random memory latency, decode stalls and redirects against a queue model
  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic [15:0] m_addr;
    logic [15:0] m_pend;
    logic        m_disc;
    logic        m_halt;
    logic        exp_req;
    logic        ack_i, red_i, rdy_i, acc, popv;
    logic [15:0] rpc_i;
    logic [23:0] data_i;
    do_reset();
    q.delete();
    m_addr = 16'h0000;
    m_pend = 16'h0000;
    m_disc = 1'b0;
    m_halt = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      exp_req = m_halt ? 1'b0 : (m_disc ? 1'b1 : (q.size() < DEPTH));
      n_cmp++;
      if ({bus.MemReq, bus.MemAddr} !== {exp_req, m_addr}) begin
        n_err++; $display("FAIL rnd_req c%0d: got %h want %h", cyc, {bus.MemReq, bus.MemAddr}, {exp_req, m_addr});
      end
      n_cmp++;
      if (bus.InstrValid !== (q.size() != 0)) begin
        n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, bus.InstrValid, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_cmp++;
        if ({bus.InstrPC, bus.Instr, bus.Opcode} !== {q[0].pc, q[0].d, q[0].d[23:20]}) begin
          n_err++; $display("FAIL rnd_head c%0d: got %h want %h", cyc, {bus.InstrPC, bus.Instr, bus.Opcode},
                            {q[0].pc, q[0].d, q[0].d[23:20]});
        end
      end
      ack_i  = ($urandom_range(0, 99) < 55);
      red_i  = ($urandom_range(0, 99) < 8);
      rdy_i  = ($urandom_range(0, 99) < 70);
      rpc_i  = 16'($urandom);
      data_i = mem_word(m_addr);
      drive(ack_i, data_i, red_i, rpc_i, rdy_i);

      acc  = ack_i && exp_req;
      popv = (q.size() != 0) && rdy_i;
      if (red_i) begin
        q.delete();
        if (m_halt) begin
          m_addr = rpc_i;
          m_halt = 1'b0;
        end else if (m_disc) begin
          if (acc) begin
            m_addr = rpc_i;
            m_disc = 1'b0;
          end else begin
            m_pend = rpc_i;
          end
        end else if (!exp_req || acc) begin
          m_addr = rpc_i;
        end else begin
          m_disc = 1'b1;
          m_pend = rpc_i;
        end
      end else begin
        if (popv) void'(q.pop_front());
        if (m_disc) begin
          if (acc) begin
            m_addr = m_pend;
            m_disc = 1'b0;
          end
        end else if (!m_halt && acc) begin
          e.pc = m_addr;
          e.d  = data_i;
          q.push_back(e);
          m_addr = m_addr + 16'd1;
`ifdef HALT_DETECT_EN
          if (data_i[23:20] == 4'hF) m_halt = 1'b1;
`endif
        end
      end
      tick();
    end
    drive(1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b0, 24'h0, 1'b0, 16'h0, 1'b0);
    drive2(1'b0, 24'h0, 1'b0);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_delayed_ack();
    test_redirect_ack_pop();
    test_wrap();
    test_opcode_f();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end of the 24-bit CPU: holds the fetch PC, issues word reads to instruction memory over a request/acknowledge handshake, and buffers returned instructions in a small FIFO. It sits upstream of the control/ALU-control decode, presenting a 24-bit instruction, its PC and its 4-bit opcode field under a valid/ready handshake. Branch resolution redirects it through a flush port.

## Interface

- PC_W, 16: instruction word-address width.
- INSTR_W, 24: instruction width.
- DEPTH, 2: FIFO entries, at least 2.
- RESET_PC, 0: fetch address after reset.

- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MemReq  out  1  read request to instruction memory.
- MemAddr  out  PC_W  word address of the request.
- MemAck  in  1  memory accepted the request; MemData valid this cycle.
- MemData  in  INSTR_W  instruction word, sampled when MemAck=1.
- Redirect  in  1  branch/jump taken: flush and refetch.
- RedirectPC  in  PC_W  new fetch address, sampled when Redirect=1.
- InstrValid  out  1  FIFO head is valid.
- InstrReady  in  1  decode accepts the head.
- Instr  out  INSTR_W  FIFO head instruction.
- InstrPC  out  PC_W  address of Instr.
- Opcode  out  4  Instr[23:20].

## Operation

- Storage:
  - FetchPC register drives MemAddr.
  - PendingPC register.
  - FIFO of {PC, instruction}, DEPTH entries, with a count.
- States are FETCH, DISCARD and HALTED (HALTED exists only with the macro defined). Reset state is FETCH.
- MemReq is 1 in FETCH when count < DEPTH, and 1 in DISCARD. It is 0 in HALTED and while Reset is high.
- A full FIFO blocks a new request even if a pop happens in the same cycle.
- Memory rule: once MemReq=1, MemReq and MemAddr stay stable until the MemAck cycle. MemAck is ignored when MemReq=0.
- FETCH with MemAck and no Redirect:
  - Push {FetchPC, MemData}.
  - FetchPC <= FetchPC+1, modulo 2^PC_W (wraps to 0).
- Pop: when InstrValid & InstrReady, advance the FIFO head.
- Push and pop may occur in the same cycle; count is then unchanged.
- Redirect has priority over push and pop. The FIFO is cleared (count=0) in the Redirect cycle.
- Redirect in FETCH:
  - With MemReq=0 or MemAck=1: FetchPC <= RedirectPC and the state stays FETCH. Any acked data is dropped.
  - With MemReq=1 and MemAck=0: PendingPC <= RedirectPC, go to DISCARD. FetchPC is held.
- DISCARD:
  - Hold the request until MemAck.
  - On MemAck, drop the data, FetchPC <= PendingPC, go to FETCH.
  - A Redirect in DISCARD without MemAck updates PendingPC.
  - A Redirect in DISCARD with MemAck sets FetchPC <= RedirectPC and goes to FETCH.
- Opcode is always Instr[23:20]. Instr, InstrPC and Opcode are don't-care when InstrValid=0, but are driven from the FIFO head register (no X).

## Timing

- Reset values:
  - MemReq=0, MemAddr=RESET_PC.
  - InstrValid=0, Instr=0, InstrPC=0, Opcode=0.
  - count=0, PendingPC=0, state FETCH.
- The first MemReq is asserted in the first cycle after Reset falls.
- Latency: MemAck in cycle N gives InstrValid=1 in cycle N+1.
- Throughput is one instruction per cycle, given MemAck every cycle and InstrReady held high.
- Redirect in cycle N:
  - InstrValid=0 in N+1.
  - A request to RedirectPC is presented in N+1, or in the cycle after the discarded ack.
- Reset asserted mid-transaction abandons the outstanding request immediately. All registers take their reset values asynchronously.

## Configuration

- HALT_DETECT_EN:
  - Defined: when FETCH pushes a word whose bits [23:20] are 4'b1111, that word is enqueued normally, the state moves to HALTED and MemReq drops. Only Redirect leaves HALTED (FetchPC <= RedirectPC, go to FETCH); the FIFO keeps draining while HALTED.
  - Not defined: opcode 4'b1111 is fetched like any other word, and the HALTED state does not exist.

## Test plan

- Reset release, MemAck every cycle with MemData = 24'h10_0000 + addr, InstrReady=1: MemAddr runs 0,1,2,3…; InstrPC/Instr follow one cycle later; Opcode=4'h1.
- InstrReady=0 for 5 cycles: after 2 pushes count=2, MemReq=0, FetchPC=2. On InstrReady=1, the head pops (PC 0 then 1) and MemReq reasserts at MemAddr=2.
- MemAck delayed 3 cycles, Redirect to 16'h0040 in request cycle 1:
  - MemAddr stays at the old address until the ack, and the returned data is never presented.
  - The next request is 16'h0040; InstrValid is 0 until it returns.
- Redirect with simultaneous MemAck and pop, RedirectPC=16'h0100: FIFO empty next cycle, MemAddr=16'h0100, acked word dropped.
- RESET_PC=16'hFFFF: first fetch at FFFF, next at 0000 (wrap).
- With HALT_DETECT_EN, MemData=24'hF00000 at address 3:
  - The word is presented with Opcode=4'hF, and MemReq stays 0 afterwards.
  - Redirect to 16'h0008 resumes fetching at 8.
  - Reset asserted mid-DISCARD: MemReq=0 immediately, and after release the fetch starts at RESET_PC.
